// File: rtl/sub_pipe.sv
// Two-stage pipelined fixed-point subtractor (res = a - b) with valid/ready flow control.
// Both all-zeros and the sign-bit-only pattern are treated as zero operands.
module sub_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             borrow
);

  localparam logic [WIDTH-1:0] NegZero = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] One     = {{(WIDTH-1){1'b0}}, 1'b1};

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             az_q, bz_q;

  // Stage 2 state
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;

  logic             in_xfer;
  logic             s1_adv;
  logic [WIDTH:0]   raw_diff;
  logic [WIDTH-1:0] neg_b;

  assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);

  assign raw_diff = {1'b0, a_q} - {1'b0, b_q};
  assign neg_b    = ~b_q + One;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // A zero subtrahend wins over a zero minuend, so 0 - 0 returns a unchanged.
  always_comb begin
    res_d    = raw_diff[WIDTH-1:0];
    borrow_d = raw_diff[WIDTH];
    if (bz_q) begin
      res_d    = a_q;
      borrow_d = 1'b0;
    end else if (az_q) begin
      res_d    = neg_b;
      borrow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      az_q       <= 1'b0;
      bz_q       <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (in_xfer) begin
        a_q  <= a;
        b_q  <= b;
        az_q <= (a == '0) || (a == NegZero);
        bz_q <= (b == '0) || (b == NegZero);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      borrow_q   <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s1_adv) begin
        res_q    <= res_d;
        borrow_q <= borrow_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign res       = res_q;
  assign borrow    = borrow_q;

endmodule

// File: tb/tb_sub_pipe.sv
// Directed-vector and scoreboard bench for the pipelined subtractor.
`timescale 1ns/1ps
module tb_sub_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        borrow;

  int checks = 0;
  int errors = 0;

  sub_pipe #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .borrow    (borrow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] exp_res;
    logic        exp_borrow;
  } vec_t;

  vec_t vecs[12];

  logic [32:0] exp_q[$];
  bit          mon_en = 1'b0;
  int          n_out  = 0;
  bit          acc, outx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: {borrow, res}
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y);
    logic [32:0] r;
    if (y == 32'h0 || y == 32'h8000_0000) begin
      r = {1'b0, x};
    end else if (x == 32'h0 || x == 32'h8000_0000) begin
      r = {1'b0, 32'h0 - y};
    end else begin
      r = {1'b0, x} - {1'b0, y};
    end
    return r;
  endfunction

  // One clock: observe at the falling edge, return 1ns after the rising edge.
  task automatic tick();
    logic [32:0] e;
    @(negedge clk);
    acc  = in_valid && in_ready;
    outx = out_valid && out_ready;
    if (mon_en) begin
      if (acc) exp_q.push_back(model(a, b));
      if (outx) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {31'h0, borrow, res}, 64'h1_dead_beef);
        end else begin
          e = exp_q.pop_front();
          chk("stream_result", {31'h0, borrow, res}, {31'h0, e});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, guard, idx;
    logic [31:0] sa[8], sb[8];
    logic [32:0] first;

    vecs[0]  = '{32'd5,         32'd3,         32'd2,         1'b0};
    vecs[1]  = '{32'd3,         32'd5,         32'hFFFF_FFFE, 1'b1};
    vecs[2]  = '{32'h8000_0000, 32'd7,         32'hFFFF_FFF9, 1'b0};
    vecs[3]  = '{32'd9,         32'h8000_0000, 32'd9,         1'b0};
    vecs[4]  = '{32'd0,         32'd0,         32'd0,         1'b0};
    vecs[5]  = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0};
    vecs[6]  = '{32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0};
    vecs[7]  = '{32'd1,         32'd2,         32'hFFFF_FFFF, 1'b1};
    vecs[8]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[9]  = '{32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFE, 1'b0};
    vecs[10] = '{32'd0,         32'h8000_0001, 32'h7FFF_FFFF, 1'b0};
    vecs[11] = '{32'h1234_5678, 32'h1234_5678, 32'd0,         1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_res",       {32'h0, res},       64'h0);
    chk("rst_borrow",    {63'h0, borrow},    64'h0);
    chk("rst_in_ready",  {63'h0, in_ready},  64'h1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, one at a time, checking the two-edge latency
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      in_valid = 1'b1; a = vecs[i].va; b = vecs[i].vb;
      tick();
      chk("vec_accept", {63'h0, acc}, 64'h1);
      in_valid = 1'b0;
      chk("vec_not_early", {63'h0, out_valid}, 64'h0);
      tick();
      chk("vec_valid", {63'h0, out_valid}, 64'h1);
      chk("vec_res", {32'h0, res}, {32'h0, vecs[i].exp_res});
      chk("vec_borrow", {63'h0, borrow}, {63'h0, vecs[i].exp_borrow});
      tick();
      chk("vec_drained", {63'h0, out_valid}, 64'h0);
    end

    // Stall: 8 pairs, out_ready low for 5 cycles after the pipe fills
    for (int i = 0; i < 8; i++) begin
      sa[i] = $urandom; sb[i] = $urandom;
    end
    sb[3] = 32'h8000_0000;
    sa[5] = 32'h0;
    first = model(sa[0], sb[0]);
    mon_en = 1'b1; n_out = 0; idx = 0;
    out_ready = 1'b0; in_valid = 1'b1; a = sa[0]; b = sb[0];
    for (int c = 0; c < 2; c++) begin
      tick();
      if (acc) idx++;
      a = sa[idx]; b = sb[idx];
    end
    chk("stall_accepts", idx, 64'd2);
    chk("stall_in_ready_low", {63'h0, in_ready}, 64'h0);
    for (int c = 0; c < 5; c++) begin
      tick();
      if (acc) idx++;
      a = sa[idx]; b = sb[idx];
      chk("stall_hold_valid", {63'h0, out_valid}, 64'h1);
      chk("stall_hold_res", {31'h0, borrow, res}, {31'h0, first});
      chk("stall_in_ready", {63'h0, in_ready}, 64'h0);
    end
    out_ready = 1'b1;
    guard = 0;
    while (n_out < 8 && guard < 40) begin
      tick();
      guard++;
      chk("stream_no_gap", {63'h0, outx}, 64'h1);
      if (acc) begin
        idx++;
        if (idx < 8) begin
          a = sa[idx]; b = sb[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("stall_count", n_out, 64'd8);
    chk("stall_queue_empty", exp_q.size(), 64'd0);

    // Random handshake traffic against the reference model
    n_out = 0; sent = 0; guard = 0;
    in_valid = 1'b0;
    while ((n_out < 1000) && guard < 20000) begin
      if (!in_valid || acc) begin
        if (acc) sent++;
        a = $urandom;
        b = $urandom;
        if ($urandom_range(0, 7) == 0) b = 32'h8000_0000;
        if ($urandom_range(0, 7) == 0) a = 32'h0;
        in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      guard++;
    end
    if (acc) sent++;
    in_valid = 1'b0;
    chk("rand_outputs", n_out, 64'd1000);
    chk("rand_inputs", sent, 64'd1000);
    chk("rand_queue_empty", exp_q.size(), 64'd0);

    // Asynchronous reset with both stages full
    mon_en = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; a = 32'd100; b = 32'd1;
    tick();
    a = 32'd200; b = 32'd2;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_full", {62'h0, out_valid, in_ready}, 64'h2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("async_rst_in_ready",  {63'h0, in_ready},  64'h1);
    exp_q.delete();
    tick();
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("no_stale_output", {63'h0, out_valid}, 64'h0);
    end
    in_valid = 1'b1; a = 32'd10; b = 32'd4;
    tick();
    in_valid = 1'b0;
    tick();
    chk("post_rst_res", {31'h0, out_valid, borrow, res}, {31'h0, 1'b1, 1'b0, 32'd6});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
